// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit: PC width, reset PC,
// fetch FSM encoding and the decode-side output payload.
package instr_fetch_unit_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ALIGN_BITS = 2;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_3000;
    localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_WAIT = 2'd2
    } fetch_state_t;

    // One buffered instruction handed to decode
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_pkt_t;

    // Force an address onto a word boundary
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:ALIGN_BITS], ALIGN_BITS'(0)};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: imem request/response, next-PC redirect and decode output.
// The master side is the fetch unit; the slave side is imem plus decode/execute.
interface instr_fetch_unit_if;
    import instr_fetch_unit_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;

    modport master (
        output imem_req_valid,
        input  imem_req_ready,
        output imem_req_addr,
        input  imem_resp_valid,
        input  imem_resp_data,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_instr
    );

    modport slave (
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_req_addr,
        output imem_resp_valid,
        output imem_resp_data,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_instr
    );

endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, keeps one imem request outstanding,
// buffers each returned word with its PC for decode and honours redirects.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               reset,
    instr_fetch_unit_if.master fif
);

    fetch_state_t    state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic [XLEN-1:0] inflight_pc, inflight_pc_n;
    logic            drop, drop_n;
    logic            out_valid, out_valid_n;
    fetch_pkt_t      obuf, obuf_n;
    logic            req_valid_c;
    logic            req_fire_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FETCH_IDLE;
            pc          <= RESET_PC;
            inflight_pc <= '0;
            drop        <= 1'b0;
            out_valid   <= 1'b0;
            obuf        <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            inflight_pc <= inflight_pc_n;
            drop        <= drop_n;
            out_valid   <= out_valid_n;
            obuf        <= obuf_n;
        end
    end

    always_comb begin
        state_n       = state;
        pc_n          = pc;
        inflight_pc_n = inflight_pc;
        drop_n        = drop;
        out_valid_n   = out_valid;
        obuf_n        = obuf;
        req_valid_c   = 1'b0;
        req_fire_c    = 1'b0;

        // A decode handshake empties the buffer unless a response refills it below
        if (out_valid && fif.out_ready) begin
            out_valid_n = 1'b0;
        end

        case (state)
            FETCH_IDLE: begin
                state_n = FETCH_REQ;
            end
            FETCH_REQ: begin
                // Only request when the buffer will be free by the time the word lands
                req_valid_c = !out_valid || fif.out_ready;
                req_fire_c  = req_valid_c && fif.imem_req_ready;
                if (req_fire_c) begin
                    inflight_pc_n = pc;
                    state_n       = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (fif.imem_resp_valid) begin
                    state_n = FETCH_REQ;
                    if (drop) begin
                        drop_n = 1'b0;
                    end else begin
                        obuf_n.pc    = inflight_pc;
                        obuf_n.instr = fif.imem_resp_data;
                        out_valid_n  = 1'b1;
                        pc_n         = inflight_pc + PC_STEP;
                    end
                end
            end
            default: begin
                state_n = FETCH_IDLE;
            end
        endcase

        // Redirect overrides the normal update; an issued request becomes a dropped one
        if (fif.redirect_valid) begin
            pc_n        = word_align(fif.redirect_pc);
            out_valid_n = 1'b0;
            obuf_n      = obuf;
            case (state)
                FETCH_REQ: begin
                    if (req_fire_c) begin
                        drop_n = 1'b1;
                    end
                end
                FETCH_WAIT: begin
                    drop_n = !fif.imem_resp_valid;
                end
                default: begin
                    drop_n = drop;
                end
            endcase
        end
    end

    assign fif.imem_req_valid = req_valid_c;
    assign fif.imem_req_addr  = pc;
    assign fif.out_valid      = out_valid;
    assign fif.out_pc         = obuf.pc;
    assign fif.out_instr      = obuf.instr;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a transaction-level fetch model checked every cycle,
// directed scenarios driving imem/redirect/decode, and literal expectations per scenario.
module tb_instr_fetch_unit;

    logic clk;
    logic reset;

    instr_fetch_unit_if fif ();

    instr_fetch_unit dut (
        .clk   (clk),
        .reset (reset),
        .fif   (fif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] req_log[$];
    logic [31:0] dlv_pc[$];
    logic [31:0] dlv_instr[$];

    // imem responder state
    bit          pend;
    logic [31:0] paddr;
    int          pcnt;
    int          resp_lat;

    // fetch model: next fetch address, outstanding request, decode buffer
    logic [31:0] m_pc;
    bit          m_idle;
    bit          m_out;
    bit          m_kill;
    logic [31:0] m_ppc;
    bit          m_ov;
    logic [31:0] m_opc;
    logic [31:0] m_oinstr;
    bit          exp_req;
    bit          hs;
    bit          fire;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'h2408, a[15:0]};
    endfunction

    function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hBAD0_BAD0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, then advance the model across the coming edge
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_out_valid", {31'd0, fif.out_valid}, 32'd0);
            chk("rst_req_valid", {31'd0, fif.imem_req_valid}, 32'd0);
            chk("rst_out_pc", fif.out_pc, 32'd0);
            chk("rst_out_instr", fif.out_instr, 32'd0);
            m_pc = 32'h0000_3000; m_idle = 1; m_out = 0; m_kill = 0;
            m_ov = 0; m_opc = 0; m_oinstr = 0; m_ppc = 0;
        end else begin
            exp_req = !m_idle && !m_out && !(m_ov && !fif.out_ready);
            chk("req_valid", {31'd0, fif.imem_req_valid}, {31'd0, exp_req});
            if (exp_req) chk("req_addr", fif.imem_req_addr, m_pc);
            chk("out_valid", {31'd0, fif.out_valid}, {31'd0, m_ov});
            if (m_ov) begin
                chk("out_pc", fif.out_pc, m_opc);
                chk("out_instr", fif.out_instr, m_oinstr);
            end
            hs   = m_ov && fif.out_ready;
            fire = exp_req && fif.imem_req_ready;
            if (fire) req_log.push_back(m_pc);
            if (hs) begin
                dlv_pc.push_back(m_opc);
                dlv_instr.push_back(m_oinstr);
                m_ov = 0;
            end
            if (fif.redirect_valid) begin
                m_pc = fif.redirect_pc & 32'hFFFF_FFFC;
                m_ov = 0;
                if (m_out && fif.imem_resp_valid) begin
                    m_out = 0; m_kill = 0;
                end else if (m_out) begin
                    m_kill = 1;
                end else if (fire) begin
                    m_out = 1; m_kill = 1;
                end
            end else if (fire) begin
                m_out = 1; m_ppc = m_pc; m_kill = 0;
            end else if (m_out && fif.imem_resp_valid) begin
                m_out = 0;
                if (!m_kill) begin
                    m_ov = 1; m_opc = m_ppc; m_oinstr = fif.imem_resp_data;
                    m_pc = m_ppc + 32'd4;
                end
                m_kill = 0;
            end
            m_idle = 0;
        end
    end

    // One clock: note an accepted request, then drive pulses and the imem response
    task automatic tick();
        @(negedge clk);
        if (!reset && fif.imem_req_valid && fif.imem_req_ready) begin
            pend = 1; paddr = fif.imem_req_addr; pcnt = resp_lat;
        end
        @(posedge clk);
        #1;
        fif.imem_resp_valid = 1'b0;
        fif.redirect_valid  = 1'b0;
        if (reset) pend = 0;
        if (pend) begin
            pcnt--;
            if (pcnt <= 0) begin
                fif.imem_resp_valid = 1'b1;
                fif.imem_resp_data  = mem_word(paddr);
                pend = 0;
            end
        end
    endtask

    task automatic clear_logs();
        req_log.delete();
        dlv_pc.delete();
        dlv_instr.delete();
    endtask

    task automatic drain();
        fif.imem_req_ready = 1'b0;
        fif.out_ready      = 1'b1;
        repeat (8) tick();
        clear_logs();
    endtask

    task automatic wait_req(input int n);
        int k = 0;
        while (req_log.size() < n && k < 50) begin tick(); k++; end
        chk("wait_req_count", 32'(req_log.size()), 32'(n));
    endtask

    task automatic wait_deliv(input int n);
        int k = 0;
        while (dlv_pc.size() < n && k < 60) begin tick(); k++; end
        chk("wait_deliv_count", 32'(dlv_pc.size()), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        fif.imem_req_ready  = 1'b0;
        fif.imem_resp_valid = 1'b0;
        fif.imem_resp_data  = 32'd0;
        fif.redirect_valid  = 1'b0;
        fif.redirect_pc     = 32'd0;
        fif.out_ready       = 1'b0;
        pend = 0; paddr = 0; pcnt = 0; resp_lat = 1;
        repeat (3) tick();

        // 1: streaming from reset PC
        reset = 1'b0;
        fif.out_ready = 1'b1;
        fif.imem_req_ready = 1'b1;
        wait_deliv(3);
        chk("t1_req0", qat(req_log, 0), 32'h0000_3000);
        chk("t1_req1", qat(req_log, 1), 32'h0000_3004);
        chk("t1_req2", qat(req_log, 2), 32'h0000_3008);
        chk("t1_pc0", qat(dlv_pc, 0), 32'h0000_3000);
        chk("t1_pc2", qat(dlv_pc, 2), 32'h0000_3008);
        chk("t1_instr0", qat(dlv_instr, 0), 32'h2408_3000);
        chk("t1_instr1", qat(dlv_instr, 1), 32'h2408_3004);

        // 2: decode stall holds the buffer and blocks requests
        drain();
        fif.out_ready = 1'b0;
        fif.redirect_valid = 1'b1;
        fif.redirect_pc = 32'h0000_5000;
        tick();
        fif.imem_req_ready = 1'b1;
        for (int k = 0; k < 20 && !fif.out_valid; k++) tick();
        repeat (5) tick();
        #1;
        chk("t2_hold_valid", {31'd0, fif.out_valid}, 32'd1);
        chk("t2_hold_pc", fif.out_pc, 32'h0000_5000);
        chk("t2_hold_instr", fif.out_instr, 32'h2408_5000);
        chk("t2_req_blocked", {31'd0, fif.imem_req_valid}, 32'd0);
        fif.out_ready = 1'b1;
        #1;
        chk("t2_req_same_cycle", {31'd0, fif.imem_req_valid}, 32'd1);
        chk("t2_req_addr", fif.imem_req_addr, 32'h0000_5004);
        repeat (3) tick();

        // 3: redirect during WAIT, stale response arrives later
        drain();
        resp_lat = 3;
        fif.imem_req_ready = 1'b1;
        wait_req(1);
        fif.redirect_valid = 1'b1;
        fif.redirect_pc = 32'h0000_4002;
        tick();
        resp_lat = 1;
        wait_deliv(1);
        chk("t3_req_after", qat(req_log, 1), 32'h0000_4000);
        chk("t3_pc", qat(dlv_pc, 0), 32'h0000_4000);
        chk("t3_instr", qat(dlv_instr, 0), 32'h2408_4000);

        // 4a: redirect coincident with the response
        drain();
        resp_lat = 2;
        fif.imem_req_ready = 1'b1;
        wait_req(1);
        tick();
        fif.redirect_valid = 1'b1;
        fif.redirect_pc = 32'h0000_6000;
        tick();
        resp_lat = 1;
        wait_deliv(1);
        chk("t4a_req_after", qat(req_log, 1), 32'h0000_6000);
        chk("t4a_pc", qat(dlv_pc, 0), 32'h0000_6000);

        // 4b: redirect coincident with a request handshake
        drain();
        fif.imem_req_ready = 1'b1;
        fif.redirect_valid = 1'b1;
        fif.redirect_pc = 32'h0000_7000;
        tick();
        wait_deliv(1);
        chk("t4b_req_count_min", {31'd0, req_log.size() >= 2}, 32'd1);
        chk("t4b_req_after", qat(req_log, 1), 32'h0000_7000);
        chk("t4b_pc", qat(dlv_pc, 0), 32'h0000_7000);

        // 5: PC wrap at the top of the address space
        drain();
        fif.redirect_valid = 1'b1;
        fif.redirect_pc = 32'hFFFF_FFFF;
        tick();
        fif.imem_req_ready = 1'b1;
        wait_deliv(2);
        chk("t5_req0", qat(req_log, 0), 32'hFFFF_FFFC);
        chk("t5_req1", qat(req_log, 1), 32'h0000_0000);
        chk("t5_pc0", qat(dlv_pc, 0), 32'hFFFF_FFFC);
        chk("t5_instr0", qat(dlv_instr, 0), 32'h2408_FFFC);
        chk("t5_pc1", qat(dlv_pc, 1), 32'h0000_0000);

        // 6: reset during WAIT, old response returned after release
        drain();
        resp_lat = 3;
        fif.imem_req_ready = 1'b1;
        wait_req(1);
        tick();
        #2;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        clear_logs();
        resp_lat = 1;
        fif.imem_resp_valid = 1'b1;
        fif.imem_resp_data = 32'hDEAD_BEEF;
        #1;
        chk("t6_out_valid_idle", {31'd0, fif.out_valid}, 32'd0);
        wait_deliv(1);
        chk("t6_req0", qat(req_log, 0), 32'h0000_3000);
        chk("t6_pc0", qat(dlv_pc, 0), 32'h0000_3000);
        chk("t6_instr0", qat(dlv_instr, 0), 32'h2408_3000);
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
